id_ex_stage: RTL and testbench

ID/EX pipeline register with load-use hazard detection for the five-stage MIPS core. Each cycle it captures the 32-bit control word from the main decoder, the register-file operands, the sign-extended immediate and the register indices, and presents them to EX as registered fields. When a `lw` in EX writes a register that the instruction in ID reads, it inserts a one-cycle bubble and asserts `stall_o` so that PC and IF/ID hold. A saturating counter records the number of inserted bubbles.

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/hazard_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: control-word layout, ALUOp codes, opcodes.
// Latency: none (package only).
// Backpressure: not applicable.
package cpu_pkg;

    // Bit positions inside the 32-bit decoder control word
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUOP_LO = 4;
    localparam int CTRL_ALUOP_HI = 5;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_REGDST   = 7;

    // ALU operation selected by the main decoder
    typedef enum logic [1:0] {
        ALUOP_RTYPE = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_OR    = 2'b10,
        ALUOP_SUB   = 2'b11
    } aluop_e;

    // Primary opcodes decoded in ID
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Control fields that travel from ID to EX
    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic [1:0] aluop;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       regwrite;
    } ex_ctrl_t;

    // Unpack the low byte of the control word into the EX control bundle
    function automatic ex_ctrl_t unpack_ctrl(input logic [7:0] ctrl);
        ex_ctrl_t c;
        c.regwrite = ctrl[CTRL_REGWRITE];
        c.memtoreg = ctrl[CTRL_MEMTOREG];
        c.memread  = ctrl[CTRL_MEMREAD];
        c.memwrite = ctrl[CTRL_MEMWRITE];
        c.aluop    = ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
        c.alusrc   = ctrl[CTRL_ALUSRC];
        c.regdst   = ctrl[CTRL_REGDST];
        return c;
    endfunction

    // rt is read by R-type, sw and beq; rs is read by everything
    function automatic logic rt_is_source(input logic [7:0] ctrl, input logic branch);
        return ctrl[CTRL_REGDST] | ctrl[CTRL_MEMWRITE] | branch;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a lw in EX loads.
// Latency: purely combinational.
// Backpressure: output drives the pipeline stall; it has no inputs of its own to hold.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             rt_used_i,
    output logic             hazard_o
);

    logic rs_match;
    logic rt_match;
    logic ex_rt_nonzero;

    // $0 is hardwired, so a load to it never creates a dependency
    assign ex_rt_nonzero = (ex_rt_i != '0);
    assign rs_match      = (ex_rt_i == id_rs_i);
    assign rt_match      = (ex_rt_i == id_rt_i) & rt_used_i;

    assign hazard_o = ex_memread_i & ex_rt_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// Latency: one clock from ID inputs to ex_* outputs; stall_o is combinational in the same cycle.
// Backpressure: EX never stalls; on a load-use hazard stall_o holds PC and IF/ID for one cycle.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       ctrl_i,
    input  logic              branch_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              ex_regwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_alusrc_o,
    output logic              ex_regdst_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_W-1:0]  ex_rs_o,
    output logic [REG_W-1:0]  ex_rt_o,
    output logic [REG_W-1:0]  ex_rd_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // Upper control-word bits belong to later decoder extensions
    logic unused_ctrl_hi;
    assign unused_ctrl_hi = ^ctrl_i[31:8];

    ex_ctrl_t          ctrl_d,    ctrl_q;
    logic              valid_d,   valid_q;
    logic [DATA_W-1:0] pc4_q,     rs_data_q, rt_data_q, imm_q;
    logic [REG_W-1:0]  rs_q,      rt_q,      rd_q;
    logic [CNT_W-1:0]  cnt_d,     cnt_q;

    logic rt_used;
    logic hazard;
    logic bubble;
    logic cnt_full;

    assign rt_used = rt_is_source(ctrl_i[7:0], branch_i);

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .ex_memread_i (ctrl_q.memread),
        .ex_rt_i      (rt_q),
        .id_rs_i      (rs_i),
        .id_rt_i      (rt_i),
        .rt_used_i    (rt_used),
        .hazard_o     (hazard)
    );

    // A flush and a hazard in the same cycle share a single bubble
    assign bubble   = hazard | flush_i;
    assign cnt_full = (cnt_q == {CNT_W{1'b1}});

    // Bubble mux: squash control and valid, let data fields pass unchanged
    always_comb begin
        ctrl_d  = unpack_ctrl(ctrl_i[7:0]);
        valid_d = 1'b1;
        if (bubble) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end
    end

    // Saturating count of inserted bubbles
    always_comb begin
        cnt_d = cnt_q;
        if (bubble && !cnt_full) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Control and valid register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    // Operand, immediate and index register; loads every cycle, even on a bubble
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            pc4_q     <= pc4_i;
            rs_data_q <= rs_data_i;
            rt_data_q <= rt_data_i;
            imm_q     <= imm_i;
            rs_q      <= rs_i;
            rt_q      <= rt_i;
            rd_q      <= rd_i;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ex_regwrite_o = ctrl_q.regwrite;
    assign ex_memtoreg_o = ctrl_q.memtoreg;
    assign ex_memread_o  = ctrl_q.memread;
    assign ex_memwrite_o = ctrl_q.memwrite;
    assign ex_alusrc_o   = ctrl_q.alusrc;
    assign ex_regdst_o   = ctrl_q.regdst;
    assign ex_aluop_o    = ctrl_q.aluop;
    assign ex_valid_o    = valid_q;
    assign ex_pc4_o      = pc4_q;
    assign ex_rs_data_o  = rs_data_q;
    assign ex_rt_data_o  = rt_data_q;
    assign ex_imm_o      = imm_q;
    assign ex_rs_o       = rs_q;
    assign ex_rt_o       = rt_q;
    assign ex_rd_o       = rd_q;
    assign stall_o       = hazard;
    assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage with a queue-based scoreboard.
// Latency: driver pushes one expectation per cycle; monitor checks it at the following falling edge.
// Backpressure: none; the bench re-presents a stalled instruction like IF/ID would.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] ctrl_i = '0;
    logic        branch_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] pc4_i = '0, rs_data_i = '0, rt_data_i = '0, imm_i = '0;
    logic [4:0]  rs_i = '0, rt_i = '0, rd_i = '0;

    logic        ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o;
    logic        ex_alusrc_o, ex_regdst_o, ex_valid_o, stall_o;
    logic [1:0]  ex_aluop_o;
    logic [31:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, bubble_cnt_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;

    logic        u4_regwrite, u4_memtoreg, u4_memread, u4_memwrite;
    logic        u4_alusrc, u4_regdst, u4_valid, u4_stall;
    logic [1:0]  u4_aluop;
    logic [31:0] u4_pc4, u4_rs_data, u4_rt_data, u4_imm;
    logic [4:0]  u4_rs, u4_rt, u4_rd;
    logic [3:0]  u4_cnt;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .branch_i(branch_i), .flush_i(flush_i),
        .pc4_i(pc4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .ex_regwrite_o(ex_regwrite_o), .ex_memtoreg_o(ex_memtoreg_o), .ex_memread_o(ex_memread_o),
        .ex_memwrite_o(ex_memwrite_o), .ex_alusrc_o(ex_alusrc_o), .ex_regdst_o(ex_regdst_o),
        .ex_aluop_o(ex_aluop_o), .ex_valid_o(ex_valid_o), .ex_pc4_o(ex_pc4_o),
        .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
        .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation
    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .branch_i(branch_i), .flush_i(flush_i),
        .pc4_i(pc4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .ex_regwrite_o(u4_regwrite), .ex_memtoreg_o(u4_memtoreg), .ex_memread_o(u4_memread),
        .ex_memwrite_o(u4_memwrite), .ex_alusrc_o(u4_alusrc), .ex_regdst_o(u4_regdst),
        .ex_aluop_o(u4_aluop), .ex_valid_o(u4_valid), .ex_pc4_o(u4_pc4),
        .ex_rs_data_o(u4_rs_data), .ex_rt_data_o(u4_rt_data), .ex_imm_o(u4_imm),
        .ex_rs_o(u4_rs), .ex_rt_o(u4_rt), .ex_rd_o(u4_rd),
        .stall_o(u4_stall), .bubble_cnt_o(u4_cnt)
    );

    // What EX should hold, in instruction terms
    typedef struct {
        bit        regwrite, memtoreg, memread, memwrite, alusrc, regdst, valid;
        bit [1:0]  aluop;
        bit [31:0] pc4, rs_data, rt_data, imm;
        bit [4:0]  rs, rt, rd;
    } ex_t;

    typedef struct {
        ex_t         ex;
        bit          stall;
        int unsigned cnt;
        int unsigned cnt4;
    } exp_t;

    exp_t        sb_q[$];
    ex_t         model_ex;
    int unsigned model_bubbles;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one ID instruction (or a reset cycle) and push the predicted response
    task automatic issue(input bit [31:0] ctrl, input bit branch, input bit flush,
                         input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                         input bit do_rst);
        exp_t e;
        bit   rt_src, hz, bub;
        @(posedge clk_i);
        #2;
        rst_i     = ~do_rst;
        ctrl_i    = ctrl;
        branch_i  = branch;
        flush_i   = flush;
        rs_i      = rs;
        rt_i      = rt;
        rd_i      = rd;
        pc4_i     = $urandom;
        rs_data_i = $urandom;
        rt_data_i = $urandom;
        imm_i     = $urandom;
        if (do_rst) begin
            model_ex      = '{default: 0};
            model_bubbles = 0;
            e.ex = model_ex; e.stall = 1'b0; e.cnt = 0; e.cnt4 = 0;
            sb_q.push_back(e);
            return;
        end
        // A load in EX blocks any ID reader of its destination, except $0
        rt_src = ctrl[7] || ctrl[3] || branch;
        hz = model_ex.memread && model_ex.rt != 0 &&
             (model_ex.rt == rs || (rt_src && model_ex.rt == rt));
        e.ex    = model_ex;
        e.stall = hz;
        e.cnt   = model_bubbles;
        e.cnt4  = (model_bubbles > 15) ? 15 : model_bubbles;
        sb_q.push_back(e);
        bub = hz || flush;
        model_ex.pc4     = pc4_i;
        model_ex.rs_data = rs_data_i;
        model_ex.rt_data = rt_data_i;
        model_ex.imm     = imm_i;
        model_ex.rs      = rs;
        model_ex.rt      = rt;
        model_ex.rd      = rd;
        model_ex.valid    = !bub;
        model_ex.regwrite = !bub && ctrl[0];
        model_ex.memtoreg = !bub && ctrl[1];
        model_ex.memread  = !bub && ctrl[2];
        model_ex.memwrite = !bub && ctrl[3];
        model_ex.aluop    = bub ? 2'b00 : ctrl[5:4];
        model_ex.alusrc   = !bub && ctrl[6];
        model_ex.regdst   = !bub && ctrl[7];
        if (bub) model_bubbles++;
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("stall",    stall_o,        e.stall);
                chk("regwrite", ex_regwrite_o,  e.ex.regwrite);
                chk("memtoreg", ex_memtoreg_o,  e.ex.memtoreg);
                chk("memread",  ex_memread_o,   e.ex.memread);
                chk("memwrite", ex_memwrite_o,  e.ex.memwrite);
                chk("alusrc",   ex_alusrc_o,    e.ex.alusrc);
                chk("regdst",   ex_regdst_o,    e.ex.regdst);
                chk("aluop",    ex_aluop_o,     e.ex.aluop);
                chk("valid",    ex_valid_o,     e.ex.valid);
                chk("pc4",      ex_pc4_o,       e.ex.pc4);
                chk("rs_data",  ex_rs_data_o,   e.ex.rs_data);
                chk("rt_data",  ex_rt_data_o,   e.ex.rt_data);
                chk("imm",      ex_imm_o,       e.ex.imm);
                chk("rs",       ex_rs_o,        e.ex.rs);
                chk("rt",       ex_rt_o,        e.ex.rt);
                chk("rd",       ex_rd_o,        e.ex.rd);
                chk("bubble_cnt",   bubble_cnt_o, e.cnt);
                chk("bubble_cnt4",  u4_cnt,       e.cnt4);
                chk("stall_narrow", u4_stall,     e.stall);
            end
        end
    end

    localparam bit [31:0] C_ADD  = 32'h81;
    localparam bit [31:0] C_LW   = 32'h57;
    localparam bit [31:0] C_SW   = 32'h58;
    localparam bit [31:0] C_ADDI = 32'h51;
    localparam bit [31:0] C_ORI  = 32'h61;
    localparam bit [31:0] C_BEQ  = 32'h30;

    initial begin
        bit [31:0] ctab [6];
        int        sel, wait_cycles;
        ctab[0] = C_ADD; ctab[1] = C_LW; ctab[2] = C_SW;
        ctab[3] = C_ADDI; ctab[4] = C_ORI; ctab[5] = C_BEQ;
        model_ex      = '{default: 0};
        model_bubbles = 0;

        issue(0, 0, 0, 0, 0, 0, 1);
        issue(0, 0, 0, 0, 0, 0, 1);
        // add $3,$1,$2 pass-through
        issue(C_ADD, 0, 0, 1, 2, 3, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        // lw $2 then add $4,$2,$3, held once by the stall
        issue(C_LW, 0, 0, 1, 2, 0, 0);
        issue(C_ADD, 0, 0, 2, 3, 4, 0);
        issue(C_ADD, 0, 0, 2, 3, 4, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        // lw $0 then add $1,$0,$0
        issue(C_LW, 0, 0, 1, 0, 0, 0);
        issue(C_ADD, 0, 0, 0, 0, 1, 0);
        // lw $2 then addi $2,$5,1
        issue(C_LW, 0, 0, 1, 2, 0, 0);
        issue(C_ADDI, 0, 0, 5, 2, 0, 0);
        // lw $2 then beq on rt, and sw on rt
        issue(C_LW, 0, 0, 1, 2, 0, 0);
        issue(C_BEQ, 1, 0, 6, 2, 0, 0);
        issue(C_BEQ, 1, 0, 6, 2, 0, 0);
        issue(C_LW, 0, 0, 1, 2, 0, 0);
        issue(C_SW, 0, 0, 7, 2, 0, 0);
        issue(C_SW, 0, 0, 7, 2, 0, 0);
        // flush together with a hazard
        issue(C_LW, 0, 0, 1, 2, 0, 0);
        issue(C_ADD, 0, 1, 2, 3, 4, 0);
        issue(C_ADD, 0, 0, 2, 3, 4, 0);
        // saturate the narrow counter
        for (int i = 0; i < 20; i++) issue(C_ADD, 0, 1, 1, 2, 3, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        // reset in the middle of a stall
        issue(C_LW, 0, 0, 1, 3, 0, 0);
        issue(C_ADD, 0, 0, 3, 1, 5, 1);
        issue(C_ADD, 0, 0, 3, 1, 5, 0);
        // random traffic over a small register set to provoke dependencies
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 5);
            issue({$urandom_range(0, 32'hFF_FFFF), ctab[sel][7:0]}, sel == 5,
                  $urandom_range(0, 9) == 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), $urandom_range(0, 99) == 0);
        end
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 20) begin
            @(posedge clk_i);
            wait_cycles++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
